// File: rtl/xbar_cfg_pkg.sv
// Shared sizes, derived widths and FSM encodings for the crossbar config loader.
// Optional range checking is enabled with XBAR_CFG_RANGE_CHECK_EN.
package xbar_cfg_pkg;

  localparam int unsigned NUM_INPUTS  = 24;
  localparam int unsigned NUM_OUTPUTS = 30;
  localparam int unsigned SEL_W       = 5;
  localparam int unsigned CHUNK_W     = 8;

  function automatic int unsigned cfg_w(input int unsigned n_out, input int unsigned sel_w);
    return n_out * sel_w;
  endfunction

  function automatic int unsigned num_chunks(input int unsigned cw, input int unsigned chunk_w);
    return (cw + chunk_w - 1) / chunk_w;
  endfunction

  localparam int unsigned CFG_W      = cfg_w(NUM_OUTPUTS, SEL_W);
  localparam int unsigned NUM_CHUNKS = num_chunks(CFG_W, CHUNK_W);
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/xbar_cfg_range_chk.sv
// Flags any select field of a crossbar configuration that addresses a
// non-existent input. Used only when XBAR_CFG_RANGE_CHECK_EN is defined.
module xbar_cfg_range_chk
  import xbar_cfg_pkg::*;
(
  input  logic [CFG_W-1:0] cfg_i,
  output logic             out_of_range_c_o
);

  always_comb begin
    out_of_range_c_o = 1'b0;
    for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
      if (cfg_i[k*SEL_W +: SEL_W] >= SEL_W'(NUM_INPUTS)) out_of_range_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Streams crossbar select bits into a shadow register and commits them
// atomically to the active config. XBAR_CFG_RANGE_CHECK_EN adds a select range check.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               io_cfg_start,
  input  logic               io_cfg_valid,
  input  logic [CHUNK_W-1:0] io_cfg_data,
  output logic               io_cfg_ready,
  output logic               io_cfg_busy,
  output logic               io_cfg_done,
  output logic               io_cfg_err,
  output logic [CFG_W-1:0]   io_mux_configs
);

  localparam int unsigned SH_W = $clog2(CFG_W);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SH_W-1:0]  shamt_c;
  logic [CFG_W-1:0] chunk_mask_c;
  logic [CFG_W-1:0] chunk_data_c;

`ifdef XBAR_CFG_RANGE_CHECK_EN
  logic err_q, err_d;
  logic oor_c;

  xbar_cfg_range_chk u_range_chk (
    .cfg_i            (shadow_q),
    .out_of_range_c_o (oor_c)
  );
`endif

  // Place the incoming chunk at its slot; bits shifted past CFG_W fall off.
  always_comb begin
    shamt_c      = SH_W'(cnt_q) * SH_W'(CHUNK_W);
    chunk_mask_c = CFG_W'({CHUNK_W{1'b1}}) << shamt_c;
    chunk_data_c = CFG_W'(io_cfg_data) << shamt_c;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
`ifdef XBAR_CFG_RANGE_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io_cfg_start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
`ifdef XBAR_CFG_RANGE_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        // A restart wins over any chunk presented in the same cycle.
        if (io_cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (io_cfg_valid && ready_q) begin
          shadow_d = (shadow_q & ~chunk_mask_c) | chunk_data_c;
          if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
`ifdef XBAR_CFG_RANGE_CHECK_EN
        if (oor_c) begin
          err_d = 1'b1;
        end else begin
          active_d = shadow_q;
          done_d   = 1'b1;
        end
`else
        active_d = shadow_q;
        done_d   = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef XBAR_CFG_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign io_cfg_err = err_q;
`else
  assign io_cfg_err = 1'b0;
`endif

  assign io_cfg_ready   = ready_q;
  assign io_cfg_busy    = busy_q;
  assign io_cfg_done    = done_q;
  assign io_mux_configs = active_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: load, gapped load, restart, mid-load
// reset and select range handling (XBAR_CFG_RANGE_CHECK_EN aware).
module tb_xbar_cfg_loader;
  import xbar_cfg_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               io_cfg_start = 1'b0;
  logic               io_cfg_valid = 1'b0;
  logic [CHUNK_W-1:0] io_cfg_data = '0;
  logic               io_cfg_ready;
  logic               io_cfg_busy;
  logic               io_cfg_done;
  logic               io_cfg_err;
  logic [CFG_W-1:0]   io_mux_configs;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_bad = 0;
  int idle_bad = 0;

  logic [151:0] v1, va, vb, vc, vr;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_start   (io_cfg_start),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_data    (io_cfg_data),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_busy    (io_cfg_busy),
    .io_cfg_done    (io_cfg_done),
    .io_cfg_err     (io_cfg_err),
    .io_mux_configs (io_mux_configs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
    if (io_cfg_done) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse;
    io_cfg_start = 1'b1;
    step();
    io_cfg_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit gap);
    if (gap) begin
      io_cfg_valid = 1'b0;
      step();
      if (!io_cfg_ready) rdy_bad++;
    end
    if (!io_cfg_ready) rdy_bad++;
    io_cfg_valid = 1'b1;
    io_cfg_data  = d;
    step();
    io_cfg_valid = 1'b0;
  endtask

  task automatic send_all(input logic [151:0] v, input bit gap);
    for (int n = 0; n < 19; n++) send(v[n*8 +: 8], gap);
  endtask

  initial begin
    v1 = '0; va = '0; vb = '0; vc = '0;
    for (int n = 0; n < 19; n++) v1[n*8 +: 8] = 8'(n + 1);
    for (int k = 0; k < 30; k++) begin
      va[k*5 +: 5] = 5'((k * 7 + 3) % 24);
      vb[k*5 +: 5] = 5'((k * 11 + 5) % 24);
      vc[k*5 +: 5] = 5'((k * 5 + 1) % 24);
    end

    // Reset state, then 10 quiet cycles.
    step(); step();
    chk("rst_mux", io_mux_configs, '0);
    chk("rst_ready", io_cfg_ready, 1'b0);
    chk("rst_busy", io_cfg_busy, 1'b0);
    chk("rst_err", io_cfg_err, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (io_mux_configs != '0 || io_cfg_ready || io_cfg_busy || io_cfg_done) idle_bad++;
    end
    chk("idle_quiet", CFG_W'(idle_bad), '0);

    // Back-to-back load, chunk n = n+1.
    done_cnt = 0;
    start_pulse();
    chk("load_ready", io_cfg_ready, 1'b1);
    chk("load_busy", io_cfg_busy, 1'b1);
    send_all(v1, 1'b0);
    chk("commit_busy", io_cfg_busy, 1'b1);
    chk("commit_ready", io_cfg_ready, 1'b0);
    chk("commit_nodone", io_cfg_done, 1'b0);
    chk("commit_hold", io_mux_configs, '0);
    step();
    chk("v1_done", io_cfg_done, 1'b1);
    chk("v1_mux", io_mux_configs, v1[149:0]);
    chk("v1_byte0", CFG_W'(io_mux_configs[7:0]), CFG_W'(8'h01));
    chk("v1_byte1", CFG_W'(io_mux_configs[15:8]), CFG_W'(8'h02));
    chk("v1_top", CFG_W'(io_mux_configs[149:144]), CFG_W'(6'h13));
    chk("v1_idle", io_cfg_busy, 1'b0);
    step(); step();
    chk("v1_done_once", CFG_W'(done_cnt), CFG_W'(1));

    // Load A, then the v1 load again with valid toggling.
    start_pulse();
    send_all(va, 1'b0);
    step();
    chk("va_mux", io_mux_configs, va[149:0]);
    rdy_bad = 0;
    start_pulse();
    send_all(v1, 1'b1);
    step();
    chk("gap_mux", io_mux_configs, v1[149:0]);
    chk("gap_ready", CFG_W'(rdy_bad), '0);

    // Restart after 7 chunks; active stays v1 until B commits.
    start_pulse();
    for (int n = 0; n < 7; n++) send(8'hFF, 1'b0);
    chk("abort_hold", io_mux_configs, v1[149:0]);
    io_cfg_start = 1'b1;
    io_cfg_valid = 1'b1;
    io_cfg_data  = 8'hFF;
    step();
    io_cfg_start = 1'b0;
    io_cfg_valid = 1'b0;
    chk("restart_ready", io_cfg_ready, 1'b1);
    send_all(vb, 1'b0);
    chk("restart_hold", io_mux_configs, v1[149:0]);
    step();
    chk("vb_mux", io_mux_configs, vb[149:0]);

    // Reset after 10 chunks of a load following committed A.
    start_pulse();
    send_all(va, 1'b0);
    step();
    chk("va2_mux", io_mux_configs, va[149:0]);
    start_pulse();
    for (int n = 0; n < 10; n++) send(vc[n*8 +: 8], 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_mux", io_mux_configs, '0);
    chk("arst_busy", io_cfg_busy, 1'b0);
    chk("arst_ready", io_cfg_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    start_pulse();
    send_all(vc, 1'b0);
    step();
    chk("vc_done", io_cfg_done, 1'b1);
    chk("vc_mux", io_mux_configs, vc[149:0]);

    // Field 3 selects input 24, one past the last legal input.
    vr = vc;
    vr[19:15] = 5'd24;
`ifdef XBAR_CFG_RANGE_CHECK_EN
    start_pulse();
    send_all(vr, 1'b0);
    step();
    chk("rng_err", io_cfg_err, 1'b1);
    chk("rng_nodone", io_cfg_done, 1'b0);
    chk("rng_hold", io_mux_configs, vc[149:0]);
    chk("rng_idle", io_cfg_busy, 1'b0);
    start_pulse();
    chk("rng_err_clr", io_cfg_err, 1'b0);
    vr[19:15] = 5'd23;
    send_all(vr, 1'b0);
    step();
    chk("rng_ok_done", io_cfg_done, 1'b1);
    chk("rng_ok_mux", io_mux_configs, vr[149:0]);
`else
    start_pulse();
    send_all(vr, 1'b0);
    step();
    chk("pass_err", io_cfg_err, 1'b0);
    chk("pass_done", io_cfg_done, 1'b1);
    chk("pass_mux", io_mux_configs, vr[149:0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
